// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: controller state and PC-mux encodings plus the control-signals exception codes.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MEM_WAIT, EXC_FLUSH, EXC_REDIRECT} state_t;
  typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_BRANCH = 2'b01, PC_VECTOR = 2'b10, PC_EPC = 2'b11} pc_sel_t;
  localparam logic [2:0] NO_EXCEPTION     = 3'd0;
  localparam logic [2:0] ILLEGAL_INSTR    = 3'd1;
  localparam logic [2:0] UNALIGNED_ACCESS = 3'd2;
  localparam logic [2:0] BUS_ERROR        = 3'd3;
  localparam logic [2:0] SYSCALL          = 3'd4;
  localparam logic [2:0] BREAKPOINT       = 3'd5;
  localparam logic [2:0] OVERFLOW         = 3'd6;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: saturating event counter with a reset preload value.
module perf_counter #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= INIT;
    else if (inc && !(&count)) count <= count + WIDTH'(1);
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: stall/flush/redirect control for a 5-stage pipeline with precise exceptions.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_2000,
  parameter logic [31:0] STALL_PRELOAD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use_stall_in,
  input  logic [2:0]  excpt_in,
  input  logic [31:0] excpt_pc_in,
  input  logic        dmem_busy_in,
  input  logic        imem_busy_in,
  input  logic        branch_taken_in,
  input  logic        eret_in,
  output logic        pc_write,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [1:0]  pc_sel,
  output logic [31:0] exc_vector_out,
  output logic        exc_active,
  output logic [31:0] epc_out,
  output logic [2:0]  cause_out,
  output logic        double_fault_out,
  output logic [31:0] stall_cycles_out
);
  state_t      r_state;
  logic        r_exc_active;
  logic [31:0] r_epc;
  logic [2:0]  r_cause;
  logic        r_double_fault;
  logic        w_exc;
  logic        w_run;
  logic        w_take_exc;
  logic        w_do_eret;
  assign w_exc      = excpt_in != NO_EXCEPTION;
  assign w_run      = !reset && r_state == RUN;
  assign w_take_exc = w_run && w_exc && !r_exc_active;
  assign w_do_eret  = w_run && !w_take_exc && !dmem_busy_in && !imem_busy_in &&
                      !load_use_stall_in && eret_in && r_exc_active;
  assign exc_vector_out   = EXC_VECTOR;
  assign exc_active       = r_exc_active;
  assign epc_out          = r_epc;
  assign cause_out        = r_cause;
  assign double_fault_out = r_double_fault;
  always_comb begin
    {pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
    {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b000;
    pc_sel = PC_PLUS4;
    if (w_take_exc || (!reset && r_state == EXC_FLUSH)) begin
      {pc_write, mem_wb_en} = 2'b00;
      {if_id_flush, id_ex_flush, ex_mem_flush} = 3'b111;
    end else if (!reset && r_state == EXC_REDIRECT) begin
      pc_sel = PC_VECTOR;
      if_id_flush = 1'b1;
    end else if ((w_run || (!reset && r_state == MEM_WAIT)) && dmem_busy_in)
      {pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
    else if (w_run && imem_busy_in) begin
      pc_write = 1'b0;
      if_id_flush = 1'b1;
    end else if (w_run && load_use_stall_in) begin
      {pc_write, if_id_en, id_ex_en} = 3'b000;
      ex_mem_flush = 1'b1;
    end else if (w_do_eret) begin
      pc_sel = PC_EPC;
      {if_id_flush, id_ex_flush} = 2'b11;
    end else if (w_run && branch_taken_in) begin
      pc_sel = PC_BRANCH;
      {if_id_flush, id_ex_flush} = 2'b11;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state        <= RUN;
      r_exc_active   <= 1'b0;
      r_epc          <= '0;
      r_cause        <= NO_EXCEPTION;
      r_double_fault <= 1'b0;
    end else
      case (r_state)
        RUN: begin
          if (w_exc && r_exc_active) r_double_fault <= 1'b1;
          if (w_take_exc) begin
            r_cause <= excpt_in;
            r_epc   <= excpt_pc_in;
            r_state <= EXC_FLUSH;
          end else if (dmem_busy_in) r_state <= MEM_WAIT;
          else if (w_do_eret) r_exc_active <= 1'b0;
        end
        MEM_WAIT:  if (!dmem_busy_in) r_state <= RUN;
        EXC_FLUSH: r_state <= EXC_REDIRECT;
        default: begin
          r_exc_active <= 1'b1;
          r_state      <= RUN;
        end
      endcase
  perf_counter #(.WIDTH(32), .INIT(STALL_PRELOAD)) u_stall_ctr (
    .clk(clk), .reset(reset), .inc(!pc_write), .count(stall_cycles_out)
  );
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed scenario tests for pipeline_controller.
module tb_pipeline_controller;
  import pipeline_ctrl_pkg::*;
  logic clk = 0, reset = 1;
  logic load_use_stall_in = 0, dmem_busy_in = 0, imem_busy_in = 0, branch_taken_in = 0, eret_in = 0;
  logic [2:0] excpt_in = 3'd0;
  logic [31:0] excpt_pc_in = 32'd0;
  logic pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] pc_sel;
  logic [31:0] exc_vector_out, epc_out, stall_cycles_out;
  logic exc_active, double_fault_out;
  logic [2:0] cause_out;
  logic s_pw, s_ifen, s_iden, s_exen, s_wben, s_iff, s_idf, s_exf, s_exca, s_df;
  logic [1:0] s_sel;
  logic [31:0] s_vec, s_epc, s_stall;
  logic [2:0] s_cause;
  logic [9:0] ctrl;
  int checks = 0, failures = 0;
  logic [31:0] s0;
  localparam logic [9:0] C_DEF = 10'b11111_000_00, C_LU = 10'b00011_001_00, C_BR = 10'b11111_110_01,
    C_IM = 10'b01111_100_00, C_EXC = 10'b01110_111_00, C_RED = 10'b11111_100_10,
    C_DM = 10'b00000_000_00, C_ER = 10'b11111_110_11;
  assign ctrl = {pc_write, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, pc_sel};
  always #5 clk = ~clk;

  pipeline_controller dut (
    .clk(clk), .reset(reset), .load_use_stall_in(load_use_stall_in), .excpt_in(excpt_in),
    .excpt_pc_in(excpt_pc_in), .dmem_busy_in(dmem_busy_in), .imem_busy_in(imem_busy_in),
    .branch_taken_in(branch_taken_in), .eret_in(eret_in), .pc_write(pc_write), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .pc_sel(pc_sel), .exc_vector_out(exc_vector_out),
    .exc_active(exc_active), .epc_out(epc_out), .cause_out(cause_out), .double_fault_out(double_fault_out),
    .stall_cycles_out(stall_cycles_out)
  );
  pipeline_controller #(.STALL_PRELOAD(32'hFFFF_FFFE)) u_sat (
    .clk(clk), .reset(reset), .load_use_stall_in(load_use_stall_in), .excpt_in(excpt_in),
    .excpt_pc_in(excpt_pc_in), .dmem_busy_in(dmem_busy_in), .imem_busy_in(imem_busy_in),
    .branch_taken_in(branch_taken_in), .eret_in(eret_in), .pc_write(s_pw), .if_id_en(s_ifen),
    .id_ex_en(s_iden), .ex_mem_en(s_exen), .mem_wb_en(s_wben), .if_id_flush(s_iff),
    .id_ex_flush(s_idf), .ex_mem_flush(s_exf), .pc_sel(s_sel), .exc_vector_out(s_vec),
    .exc_active(s_exca), .epc_out(s_epc), .cause_out(s_cause), .double_fault_out(s_df),
    .stall_cycles_out(s_stall)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic clr();
    {load_use_stall_in, dmem_busy_in, imem_busy_in, branch_taken_in, eret_in} = 5'b0;
    excpt_in = NO_EXCEPTION;
  endtask

  task automatic test_reset();
    reset = 1; clr(); cyc(); #1;
    checks++; if (ctrl !== C_DEF) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_DEF); end
    checks++; if ({exc_active, double_fault_out, cause_out} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {exc_active, double_fault_out, cause_out}); end
    checks++; if (epc_out !== 0 || stall_cycles_out !== 0) begin failures++; $display("FAIL reset_regs epc=%h stall=%h exp=0", epc_out, stall_cycles_out); end
    checks++; if (exc_vector_out !== 32'h0000_2000) begin failures++; $display("FAIL vector got=%h exp=00002000", exc_vector_out); end
    checks++; if (s_stall !== 32'hFFFF_FFFE) begin failures++; $display("FAIL preload got=%h exp=fffffffe", s_stall); end
    reset = 0; cyc();
  endtask

  task automatic test_load_use();
    load_use_stall_in = 1; #1;
    checks++; if (ctrl !== C_LU) begin failures++; $display("FAIL load_use_ctrl got=%b exp=%b", ctrl, C_LU); end
    cyc(); clr(); #1;
    checks++; if (stall_cycles_out !== 32'd1) begin failures++; $display("FAIL load_use_stall got=%0d exp=1", stall_cycles_out); end
    checks++; if (ctrl !== C_DEF) begin failures++; $display("FAIL load_use_after got=%b exp=%b", ctrl, C_DEF); end
  endtask

  task automatic test_simple();
    branch_taken_in = 1; #1;
    checks++; if (ctrl !== C_BR) begin failures++; $display("FAIL branch got=%b exp=%b", ctrl, C_BR); end
    imem_busy_in = 1; #1;
    checks++; if (ctrl !== C_IM) begin failures++; $display("FAIL imem got=%b exp=%b", ctrl, C_IM); end
    clr(); eret_in = 1; #1;
    checks++; if (ctrl !== C_DEF) begin failures++; $display("FAIL eret_ignored got=%b exp=%b", ctrl, C_DEF); end
    cyc(); clr();
  endtask

  task automatic test_exception();
    excpt_in = UNALIGNED_ACCESS; excpt_pc_in = 32'h0000_0104; #1;
    checks++; if (ctrl !== C_EXC) begin failures++; $display("FAIL exc_run got=%b exp=%b", ctrl, C_EXC); end
    cyc(); clr(); #1;
    checks++; if (ctrl !== C_EXC) begin failures++; $display("FAIL exc_flush got=%b exp=%b", ctrl, C_EXC); end
    checks++; if (epc_out !== 32'h104 || cause_out !== UNALIGNED_ACCESS) begin failures++; $display("FAIL exc_latch epc=%h cause=%0d exp=104/2", epc_out, cause_out); end
    cyc(); #1;
    checks++; if (ctrl !== C_RED) begin failures++; $display("FAIL exc_redirect got=%b exp=%b", ctrl, C_RED); end
    cyc(); #1;
    checks++; if (exc_active !== 1'b1 || ctrl !== C_DEF) begin failures++; $display("FAIL exc_active got=%b ctrl=%b exp=1 %b", exc_active, ctrl, C_DEF); end
    excpt_in = ILLEGAL_INSTR; excpt_pc_in = 32'h200; branch_taken_in = 1; #1;
    checks++; if (ctrl !== C_BR) begin failures++; $display("FAIL double_chain got=%b exp=%b", ctrl, C_BR); end
    cyc(); clr(); #1;
    checks++; if (double_fault_out !== 1'b1 || cause_out !== UNALIGNED_ACCESS || epc_out !== 32'h104) begin failures++; $display("FAIL double_fault df=%b cause=%0d epc=%h exp=1/2/104", double_fault_out, cause_out, epc_out); end
    eret_in = 1; #1;
    checks++; if (ctrl !== C_ER) begin failures++; $display("FAIL eret got=%b exp=%b", ctrl, C_ER); end
    cyc(); clr(); #1;
    checks++; if (exc_active !== 1'b0 || double_fault_out !== 1'b1) begin failures++; $display("FAIL eret_clear act=%b df=%b exp=0/1", exc_active, double_fault_out); end
  endtask

  task automatic test_mem_wait();
    s0 = stall_cycles_out; dmem_busy_in = 1; branch_taken_in = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctrl !== C_DM) begin failures++; $display("FAIL mem_wait_%0d got=%b exp=%b", i, ctrl, C_DM); end
      cyc();
    end
    dmem_busy_in = 0; #1;
    checks++; if (stall_cycles_out !== s0 + 3) begin failures++; $display("FAIL mem_wait_stall got=%0d exp=%0d", stall_cycles_out, s0 + 3); end
    checks++; if (ctrl !== C_DEF) begin failures++; $display("FAIL mem_wait_release got=%b exp=%b", ctrl, C_DEF); end
    cyc(); #1;
    checks++; if (ctrl !== C_BR) begin failures++; $display("FAIL mem_wait_run got=%b exp=%b", ctrl, C_BR); end
    clr(); cyc();
  endtask

  task automatic test_exc_dmem_reset();
    excpt_in = BUS_ERROR; excpt_pc_in = 32'h300; dmem_busy_in = 1; #1;
    checks++; if (ctrl !== C_EXC) begin failures++; $display("FAIL exc_over_dmem got=%b exp=%b", ctrl, C_EXC); end
    cyc(); clr(); #1;
    checks++; if (ctrl !== C_EXC || cause_out !== BUS_ERROR) begin failures++; $display("FAIL exc_dmem_flush got=%b cause=%0d exp=%b/3", ctrl, cause_out, C_EXC); end
    reset = 1; #1;
    checks++; if (ctrl !== C_DEF || exc_active !== 1'b0 || double_fault_out !== 1'b0 || cause_out !== 3'd0) begin failures++; $display("FAIL reset_abort ctrl=%b act=%b df=%b cause=%0d", ctrl, exc_active, double_fault_out, cause_out); end
    cyc(); reset = 0; cyc(); #1;
    checks++; if (ctrl !== C_DEF || exc_active !== 1'b0 || stall_cycles_out !== 0) begin failures++; $display("FAIL no_redirect ctrl=%b act=%b stall=%0d exp=%b/0/0", ctrl, exc_active, stall_cycles_out, C_DEF); end
  endtask

  task automatic test_saturate();
    load_use_stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (s_stall !== 32'hFFFF_FFFF) begin failures++; $display("FAIL saturate_%0d got=%h exp=ffffffff", i, s_stall); end
    end
    clr(); #1;
    checks++; if (stall_cycles_out !== 32'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", stall_cycles_out); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_simple();
    test_exception();
    test_mem_wait();
    test_exc_dmem_reset();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
